ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 10 +
 rtl/ps2_sync_edge.sv | 26 ++
 rtl/ps2_host_tx.sv | 119 +++++++++++
 tb/tb_ps2_host_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types and command constants
package ps2_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_REL, S_FINISH
  } ps2_state_e;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchroniser for PS/2 clock/data plus clock falling-edge detect
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);
  logic [1:0] cq, dq;
  logic clk_d;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cq <= '1;
      dq <= '1;
      clk_d <= 1'b1;
    end else begin
      cq <= {cq[0], ps2_clk_i};
      dq <= {dq[0], ps2_data_i};
      clk_d <= cq[1];
    end
  assign clk_s = cq[1];
  assign data_s = dq[1];
  assign clk_fall = clk_d & ~cq[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over PS/2 and reports ACK or error
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy
);
  localparam longint INH_CYC = longint'(INHIBIT_US) * longint'(CLK_FREQ_HZ) / longint'(1_000_000);
  localparam longint TO_CYC  = longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ) / longint'(1_000_000);
  localparam longint CNT_MAX = INH_CYC > TO_CYC ? INH_CYC : TO_CYC;
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INH_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);

  ps2_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [9:0] shreg, shreg_n;
  logic err, err_n;
  logic clk_s, data_s, clk_fall;

  ps2_sync_edge u_sync (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .clk_s(clk_s), .data_s(data_s), .clk_fall(clk_fall)
  );

  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
      err <= err_n;
    end

  // One counter times the inhibit phase, then restarts at RTS as the transfer timeout
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shreg_n = shreg;
    err_n = err;
    tx_ready = 1'b0;
    tx_done = 1'b0;
    tx_error = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        cnt_n = '0;
        if (tx_valid) begin
          shreg_n = {1'b1, ~^tx_data, tx_data};
          idx_n = '0;
          err_n = 1'b0;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        ps2_data_oe = cnt == INH_LAST;
        if (cnt == INH_LAST) begin
          cnt_n = '0;
          state_n = S_RTS;
        end
      end
      S_RTS: begin
        ps2_data_oe = 1'b1;
        state_n = clk_fall ? S_SEND : S_RTS;
      end
      S_SEND: begin
        ps2_data_oe = ~shreg[0];
        if (clk_fall) begin
          shreg_n = {1'b1, shreg[9:1]};
          idx_n = idx + 1'b1;
          state_n = idx == 4'd8 ? S_ACK : S_SEND;
        end
      end
      S_ACK:
        if (clk_fall) begin
          err_n = data_s;
          state_n = data_s ? S_FINISH : S_WAIT_REL;
        end
      S_WAIT_REL: state_n = clk_s && data_s ? S_FINISH : S_WAIT_REL;
      S_FINISH: begin
        tx_done = ~err;
        tx_error = err;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (cnt == TO_LAST && state inside {S_RTS, S_SEND, S_ACK, S_WAIT_REL}) begin
      err_n = 1'b1;
      state_n = S_FINISH;
    end
  end

  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with an open-collector PS/2 device model at 12.5 kHz
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int CLK_HZ = 1_000_000;
  localparam int INH_US = 100;
  localparam int TO_US = 15000;
  localparam int INH_CYC = 100;
  localparam int TO_CYC = 15000;
  localparam int HALF = 40;
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_RESET = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, tx_done, tx_error, busy;
  logic ps2_clk_oe, ps2_data_oe, ps2_clk_i, ps2_data_i;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;

  assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(INH_US), .TIMEOUT_US(TO_US)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_error(tx_error), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, acc_cyc = 0;
  logic [10:0] exp_q[$];
  logic [10:0] cap;
  int inh_len, ovl_len, exit_cyc;
  logic pre_oe;
  logic [1:0] rst_oe;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (tx_done) begin done_cnt++; done_cyc = cyc; end
    if (tx_error) begin err_cnt++; err_cyc = cyc; end
    if (tx_valid && tx_ready && rst_n) acc_cyc = cyc;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit hold, input bit push);
    int t = 0;
    while (!tx_ready && t < 20000) begin @(negedge clk); t++; end
    if (!tx_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_ready: tx_ready stuck at %b, want 1", tx_ready);
    end
    tx_data = d;
    tx_valid = 1'b1;
    if (push) exp_q.push_back(frame_of(d));
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Device side: time the inhibit phase, then clock the frame out, sampling data while clock is low
  task automatic dev_xfer(input int mode);
    int t = 0;
    cap = 'x;
    inh_len = 0;
    ovl_len = 0;
    while (!ps2_clk_oe && t < 2000) begin @(negedge clk); t++; end
    if (!ps2_clk_oe) begin
      n_checks++; n_fail++;
      $display("FAIL inhibit_start: clk_oe %b, want 1", ps2_clk_oe);
      return;
    end
    while (ps2_clk_oe && inh_len < 5000) begin
      inh_len++;
      if (ps2_data_oe) ovl_len++;
      @(negedge clk);
    end
    exit_cyc = cyc;
    if (mode == M_SILENT) return;
    repeat (20) @(negedge clk);
    cap[0] = ps2_data_i;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      cap[i] = ps2_data_i;
      if (mode == M_RESET && i == 5) begin
        pre_oe = ps2_data_oe;
        rst_n = 1'b0;
        @(negedge clk);
        rst_oe = {ps2_clk_oe, ps2_data_oe};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dev_clk_low = 1'b0;
        return;
      end
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (mode == M_ACK) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
    n_checks++; if ({tx_done, tx_error} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b want 00", {tx_done, tx_error}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_send(input logic [7:0] d);
    int d0 = done_cnt, e0 = err_cnt;
    logic [10:0] exp;
    send_byte(d, 1'b0, 1'b1);
    dev_xfer(M_ACK);
    repeat (5) @(negedge clk);
    n_checks++; if (inh_len !== INH_CYC) begin n_fail++; $display("FAIL inhibit_len %h: got %0d want %0d", d, inh_len, INH_CYC); end
    n_checks++; if (ovl_len !== 1) begin n_fail++; $display("FAIL inhibit_data_oe %h: got %0d cycles want 1", d, ovl_len); end
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL frame %h: no expected entry", d); end
    else begin
      exp = exp_q.pop_front();
      if (cap !== exp) begin n_fail++; $display("FAIL frame %h: got %b want %b", d, cap, exp); end
    end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL done_count %h: got %0d want 1", d, done_cnt - d0); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL err_count %h: got %0d want 0", d, err_cnt - e0); end
    n_checks++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin n_fail++; $display("FAIL idle_after %h: got %b want 001", d, {ps2_clk_oe, ps2_data_oe, tx_ready}); end
  endtask

  task automatic test_nack();
    int d0 = done_cnt, e0 = err_cnt;
    logic [10:0] exp;
    send_byte(CMD_SET_RATE, 1'b0, 1'b1);
    dev_xfer(M_NACK);
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL nack_frame: no expected entry"); end
    else begin
      exp = exp_q.pop_front();
      if (cap !== exp) begin n_fail++; $display("FAIL nack_frame: got %b want %b", cap, exp); end
    end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL nack_error: got %0d want 1", err_cnt - e0); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL nack_done: got %0d want 0", done_cnt - d0); end
    n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fail++; $display("FAIL nack_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt, e0 = err_cnt, t = 0;
    send_byte(8'h00, 1'b0, 1'b0);
    dev_xfer(M_SILENT);
    while (err_cnt == e0 && t < TO_CYC + 500) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL timeout_error: got %0d want 1", err_cnt - e0); end
    n_checks++; if (err_cyc - exit_cyc !== TO_CYC) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", err_cyc - exit_cyc, TO_CYC); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
    n_checks++; if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin n_fail++; $display("FAIL timeout_idle: got %b want 100", {tx_ready, ps2_clk_oe, ps2_data_oe}); end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, e0 = err_cnt;
    pre_oe = 1'bx;
    rst_oe = 2'bxx;
    send_byte(8'h00, 1'b0, 1'b0);
    dev_xfer(M_RESET);
    n_checks++; if (pre_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_bit4: data_oe got %b want 1", pre_oe); end
    n_checks++; if (rst_oe !== 2'b00) begin n_fail++; $display("FAIL midrst_release: got %b want 00", rst_oe); end
    repeat (200) @(negedge clk);
    n_checks++; if ({done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL midrst_pulses: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
    test_send(CMD_RESET);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, e0 = err_cnt, d1, a1;
    logic [10:0] exp;
    send_byte(CMD_SET_RATE, 1'b1, 1'b1);
    tx_data = 8'hA5;
    exp_q.push_back(frame_of(8'hA5));
    dev_xfer(M_ACK);
    tx_valid = 1'b0;
    d1 = done_cyc;
    a1 = acc_cyc;
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_first: no expected entry"); end
    else begin
      exp = exp_q.pop_front();
      if (cap !== exp) begin n_fail++; $display("FAIL b2b_first: got %b want %b", cap, exp); end
    end
    n_checks++; if (a1 !== d1 + 1) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want %0d", a1, d1 + 1); end
    dev_xfer(M_ACK);
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_second: no expected entry"); end
    else begin
      exp = exp_q.pop_front();
      if (cap !== exp) begin n_fail++; $display("FAIL b2b_second: got %b want %b", cap, exp); end
    end
    n_checks++; if ({done_cnt - d0, err_cnt - e0} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL b2b_pulses: done %0d err %0d want 2 0", done_cnt - d0, err_cnt - e0); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: tx_ready got %b want 1", tx_ready); end
  endtask

  initial begin
    test_reset();
    test_send(CMD_ENABLE);
    test_send(8'h00);
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
